// File: rtl/if_fetch_if.sv
// Instruction-memory bus between the fetch stage and its memory.
// The fetch stage drives the address; the memory returns the word.
interface if_fetch_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] instruction_mem_addr_o;
  logic [DATA_WIDTH-1:0] instruction_mem_rD_i;

  modport master (
    output instruction_mem_addr_o,
    input  instruction_mem_rD_i
  );

  modport slave (
    input  instruction_mem_addr_o,
    output instruction_mem_rD_i
  );
endinterface

// File: rtl/if_fetch.sv
// Fetch stage: PC register, IF/ID pipeline register and the
// stop/drain/halt sequencer.
module if_fetch #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall_PC_i,
  input  logic                  stall_IF_ID_i,
  input  logic                  flush_IF_ID_i,
  input  logic                  Jump_i,
  input  logic [ADDR_WIDTH-1:0] jumpAddr_i,
  input  logic                  PCSrcE_i,
  input  logic [ADDR_WIDTH-1:0] branchAddrE_i,
  input  logic                  Stop_i,
  if_fetch_if.master            imem,
  output logic [ADDR_WIDTH-1:0] PCD_o,
  output logic [DATA_WIDTH-1:0] instructionD_o,
  output logic                  validD_o,
  output logic                  halted_o
);

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    HALTED
  } state_t;

  state_t                state_q, state_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] pcd_q, pcd_d;
  logic [DATA_WIDTH-1:0] ins_q, ins_d;
  logic                  vld_q, vld_d;
  logic                  halted_q;

  assign imem.instruction_mem_addr_o = pc_q;

  assign PCD_o          = pcd_q;
  assign instructionD_o = ins_q;
  assign validD_o       = vld_q;
  assign halted_o       = halted_q;

  // Next PC: a resolved branch beats a stall, which beats a jump.
  always_comb begin
    pc_d = pc_q + ADDR_WIDTH'(1);
    if (state_q != RUN)
      pc_d = pc_q;
    else if (PCSrcE_i)
      pc_d = branchAddrE_i;
    else if (stall_PC_i)
      pc_d = pc_q;
    else if (Jump_i)
      pc_d = jumpAddr_i;
    else if (Stop_i)
      pc_d = pc_q;
  end

  // Next IF/ID contents: load, hold, or insert a bubble.
  always_comb begin
    pcd_d = pc_q;
    ins_d = imem.instruction_mem_rD_i;
    vld_d = 1'b1;
    if (PCSrcE_i || flush_IF_ID_i) begin
      pcd_d = '0;
      ins_d = '0;
      vld_d = 1'b0;
    end else if (stall_IF_ID_i) begin
      pcd_d = pcd_q;
      ins_d = ins_q;
      vld_d = vld_q;
    end else if (state_q != RUN || Jump_i || Stop_i) begin
      pcd_d = '0;
      ins_d = '0;
      vld_d = 1'b0;
    end
  end

  // Stop sequencer: a stop on a branch's wrong path is dropped;
  // otherwise let the older instructions drain, then halt.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      RUN: begin
        if (Stop_i && !PCSrcE_i && !stall_IF_ID_i) begin
          state_d = DRAIN;
          cnt_d   = 2'd3;
        end
      end
      DRAIN: begin
        cnt_d = cnt_q - 2'd1;
        if (cnt_q == 2'd1)
          state_d = HALTED;
      end
      HALTED: begin
        cnt_d = '0;
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
  end

  // State registers; reset restarts fetch from address 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RUN;
      cnt_q    <= '0;
      pc_q     <= '0;
      pcd_q    <= '0;
      ins_q    <= '0;
      vld_q    <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pc_q     <= pc_d;
      pcd_q    <= pcd_d;
      ins_q    <= ins_d;
      vld_q    <= vld_d;
      halted_q <= (state_d == HALTED);
    end
  end

endmodule
